// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
//
// Avalon-MM master that reprograms the HDMI pixel-clock PLL via the PLL
// reconfiguration controller. A start strobe latches one complete PLL setting.
// The block then writes mode, N, M, C, K, bandwidth and charge pump, and
// triggers the reconfiguration. It lets the PLL settle and then waits for lock
// with a timeout.
//
// Ports
//   clk, rst_n          management clock, asynchronous active-low reset
//   start               one-cycle request, accepted only in IDLE
//   cfg_*               PLL setting, sampled on an accepted start
//   mgmt_address/write/writedata/waitrequest   Avalon-MM master port
//   pll_locked          PLL lock, asynchronous to clk
//   busy                sequence in progress
//   done                one-cycle pulse after lock
//   error               sticky lock timeout, cleared by the next accepted start
//   dbg_state           current FSM state, for observation only
//
// Handshake: mgmt_write, mgmt_address and mgmt_writedata are registered.
// They are held stable while mgmt_waitrequest is high. A beat is accepted
// in a cycle with mgmt_write=1 and mgmt_waitrequest=0. mgmt_write then
// drops for exactly one cycle before the next beat is presented.
module pll_reconfig_seq #(
    parameter int C_INDEX       = 0,
    parameter int SETTLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT  = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cfg_m_hi,
    input  logic [7:0]  cfg_m_lo,
    input  logic        cfg_m_odd,
    input  logic [7:0]  cfg_n_hi,
    input  logic [7:0]  cfg_n_lo,
    input  logic        cfg_n_bypass,
    input  logic [7:0]  cfg_c_hi,
    input  logic [7:0]  cfg_c_lo,
    input  logic        cfg_c_odd,
    input  logic [31:0] cfg_k,
    input  logic [3:0]  cfg_bw,
    input  logic [2:0]  cfg_cp,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  dbg_state
);

    localparam int MAX_CNT = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [4:0]       C_IDX        = 5'(C_INDEX);

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_N, WR_M, WR_C, WR_K, WR_BW, WR_CP, WR_START,
        SETTLE, WAIT_LOCK, DONE
    } state_t;

    state_t state, next_state;

    // Shadow copy of the setting, so cfg_* may change during a sequence.
    logic [7:0]  m_hi, m_lo, n_hi, n_lo, c_hi, c_lo;
    logic        m_odd, n_bypass, c_odd;
    logic [31:0] k;
    logic [3:0]  bw;
    logic [2:0]  cp;

    logic             lock_meta, lock_sync;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             write_d, busy_d, done_d, error_d;
    logic [5:0]       addr_d;
    logic [31:0]      data_d;
    logic             is_wr;
    logic [5:0]       wr_addr;
    logic [31:0]      wr_data;
    state_t           wr_next;
    logic             accept_start;

    assign accept_start = (state == IDLE) && start;
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_odd <= 1'b0;
            n_hi <= '0; n_lo <= '0; n_bypass <= 1'b0;
            c_hi <= '0; c_lo <= '0; c_odd <= 1'b0;
            k <= '0; bw <= '0; cp <= '0;
        end else if (accept_start) begin
            m_hi <= cfg_m_hi; m_lo <= cfg_m_lo; m_odd <= cfg_m_odd;
            n_hi <= cfg_n_hi; n_lo <= cfg_n_lo; n_bypass <= cfg_n_bypass;
            c_hi <= cfg_c_hi; c_lo <= cfg_c_lo; c_odd <= cfg_c_odd;
            k <= cfg_k; bw <= cfg_bw; cp <= cfg_cp;
        end
    end

    // Register map of the write phase: address, data and following state.
    always_comb begin
        is_wr   = 1'b1;
        wr_addr = 6'h00;
        wr_data = 32'h0;
        wr_next = IDLE;
        case (state)
            WR_MODE:  begin wr_addr = 6'h00; wr_data = 32'h0; wr_next = WR_N; end
            WR_N:     begin wr_addr = 6'h03; wr_data = {14'b0, 1'b0, n_bypass, n_hi, n_lo}; wr_next = WR_M; end
            WR_M:     begin wr_addr = 6'h04; wr_data = {14'b0, m_odd, 1'b0, m_hi, m_lo}; wr_next = WR_C; end
            WR_C:     begin wr_addr = 6'h05; wr_data = {9'b0, C_IDX, c_odd, 1'b0, c_hi, c_lo}; wr_next = WR_K; end
            WR_K:     begin wr_addr = 6'h07; wr_data = k; wr_next = WR_BW; end
            WR_BW:    begin wr_addr = 6'h08; wr_data = {28'b0, bw}; wr_next = WR_CP; end
            WR_CP:    begin wr_addr = 6'h09; wr_data = {29'b0, cp}; wr_next = WR_START; end
            // The controller stalls this beat for the whole reconfiguration,
            // so its acceptance means the PLL has been rewritten.
            WR_START: begin wr_addr = 6'h02; wr_data = 32'h1; wr_next = SETTLE; end
            default:  is_wr = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        write_d    = mgmt_write;
        addr_d     = mgmt_address;
        data_d     = mgmt_writedata;
        cnt_d      = cnt;
        error_d    = error;
        done_d     = 1'b0;
        if (is_wr) begin
            if (!mgmt_write) begin
                write_d = 1'b1;
                addr_d  = wr_addr;
                data_d  = wr_data;
            end else if (!mgmt_waitrequest) begin
                write_d    = 1'b0;
                next_state = wr_next;
                cnt_d      = '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        next_state = WR_MODE;
                        error_d    = 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        next_state = WAIT_LOCK;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_sync) begin
                        next_state = DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        error_d    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_d     = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
        busy_d = (next_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mgmt_write     <= 1'b0;
            mgmt_address   <= 6'h00;
            mgmt_writedata <= 32'h0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= next_state;
            mgmt_write     <= write_d;
            mgmt_address   <= addr_d;
            mgmt_writedata <= data_d;
            cnt            <= cnt_d;
            busy           <= busy_d;
            done           <= done_d;
            error          <= error_d;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed testbench for pll_reconfig_seq.
// A second instance with C_INDEX=3 shares all inputs and is used only for
// its C-counter write data.
module tb_pll_reconfig_seq;

    localparam int SETTLE  = 64;
    localparam int TIMEOUT = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [7:0]  cfg_m_hi, cfg_m_lo, cfg_n_hi, cfg_n_lo, cfg_c_hi, cfg_c_lo;
    logic        cfg_m_odd, cfg_n_bypass, cfg_c_odd;
    logic [31:0] cfg_k;
    logic [3:0]  cfg_bw;
    logic [2:0]  cfg_cp;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;

    logic [5:0]  mgmt_address, d3_address;
    logic        mgmt_write, d3_write;
    logic [31:0] mgmt_writedata, d3_writedata;
    logic        busy, done, error, d3_busy, d3_done, d3_error;
    logic [3:0]  dbg_state, d3_state;

    pll_reconfig_seq #(.C_INDEX(0), .SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_m_hi(cfg_m_hi), .cfg_m_lo(cfg_m_lo), .cfg_m_odd(cfg_m_odd),
        .cfg_n_hi(cfg_n_hi), .cfg_n_lo(cfg_n_lo), .cfg_n_bypass(cfg_n_bypass),
        .cfg_c_hi(cfg_c_hi), .cfg_c_lo(cfg_c_lo), .cfg_c_odd(cfg_c_odd),
        .cfg_k(cfg_k), .cfg_bw(cfg_bw), .cfg_cp(cfg_cp),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked), .busy(busy), .done(done), .error(error),
        .dbg_state(dbg_state)
    );

    pll_reconfig_seq #(.C_INDEX(3), .SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(TIMEOUT)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_m_hi(cfg_m_hi), .cfg_m_lo(cfg_m_lo), .cfg_m_odd(cfg_m_odd),
        .cfg_n_hi(cfg_n_hi), .cfg_n_lo(cfg_n_lo), .cfg_n_bypass(cfg_n_bypass),
        .cfg_c_hi(cfg_c_hi), .cfg_c_lo(cfg_c_lo), .cfg_c_odd(cfg_c_odd),
        .cfg_k(cfg_k), .cfg_bw(cfg_bw), .cfg_cp(cfg_cp),
        .mgmt_address(d3_address), .mgmt_write(d3_write),
        .mgmt_writedata(d3_writedata), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked), .busy(d3_busy), .done(d3_done), .error(d3_error),
        .dbg_state(d3_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [37:0] exp_q[$];   // {address, writedata}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_base();
        cfg_m_hi = 8'd4; cfg_m_lo = 8'd4; cfg_m_odd = 1'b0;
        cfg_n_hi = 8'd0; cfg_n_lo = 8'd0; cfg_n_bypass = 1'b1;
        cfg_c_hi = 8'd2; cfg_c_lo = 8'd1; cfg_c_odd = 1'b1;
        cfg_k = 32'hE8F5C339; cfg_bw = 4'h6; cfg_cp = 3'h2;
    endtask

    task automatic set_alt();
        cfg_m_hi = 8'd9; cfg_m_lo = 8'd7; cfg_m_odd = 1'b1;
        cfg_n_hi = 8'd3; cfg_n_lo = 8'd2; cfg_n_bypass = 1'b0;
        cfg_c_hi = 8'd5; cfg_c_lo = 8'd5; cfg_c_odd = 1'b0;
        cfg_k = 32'h12345678; cfg_bw = 4'hF; cfg_cp = 3'h7;
    endtask

    // Writes expected for the base setting, hand-encoded.
    task automatic load_exp();
        exp_q.delete();
        exp_q.push_back({6'h00, 32'h00000000});
        exp_q.push_back({6'h03, 32'h00010000});
        exp_q.push_back({6'h04, 32'h00000404});
        exp_q.push_back({6'h05, 32'h00020201});
        exp_q.push_back({6'h07, 32'hE8F5C339});
        exp_q.push_back({6'h08, 32'h00000006});
        exp_q.push_back({6'h09, 32'h00000002});
        exp_q.push_back({6'h02, 32'h00000001});
    endtask

    // Pulses start, then plays the controller side of the write phase.
    // hold: cycles of waitrequest per beat. mode 0 plain, 1 second start
    // with new cfg during the K write, 2 reset during the C write.
    // Returns in the cycle the start-register write is accepted.
    task automatic run_writes(input int hold, input int mode);
        int h = 0;
        int cyc = 1;
        bit prev_acc = 1'b0;
        bit poked = 1'b0;
        bit fin = 1'b0;
        logic [37:0] cap = '0;
        logic [37:0] e;
        load_exp();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("error_after_start", error, 0);
        for (int i = 0; i < 400 && !fin; i++) begin
            if (i > 0) begin
                step();
                cyc++;
            end
            start = 1'b0;
            if (prev_acc) chk("write_gap", mgmt_write, 0);
            prev_acc = 1'b0;
            if (mode == 1 && !poked && mgmt_write && mgmt_address == 6'h07) begin
                set_alt();
                start = 1'b1;
                poked = 1'b1;
            end
            if (mode == 2 && mgmt_write && mgmt_address == 6'h05) begin
                rst_n = 1'b0;
                #1;
                chk("rst_write", mgmt_write, 0);
                chk("rst_address", mgmt_address, 0);
                chk("rst_writedata", mgmt_writedata, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_error", error, 0);
                chk("rst_state", dbg_state, 0);
                rst_n = 1'b1;
                mgmt_waitrequest = 1'b0;
                fin = 1'b1;
            end else if (mgmt_write) begin
                if (h == 0) cap = {mgmt_address, mgmt_writedata};
                else chk("hold_stable", {mgmt_address, mgmt_writedata}, cap);
                if (h < hold) begin
                    mgmt_waitrequest = 1'b1;
                    h++;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    h = 0;
                    prev_acc = 1'b1;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    chk("write_beat", {mgmt_address, mgmt_writedata}, e);
                    if (mgmt_address == 6'h05) chk("c_index3_data", d3_writedata, 32'h000E0201);
                    if (mgmt_address == 6'h02) fin = 1'b1;
                end
            end else begin
                mgmt_waitrequest = 1'b0;
            end
        end
        chk("writes_finished", fin, 1);
        if (mode != 2) chk("writes_remaining", exp_q.size(), 0);
        if (hold == 0 && mode == 0) chk("write_cycles", cyc, 16);
    endtask

    // From the start-write accept cycle: done must appear SETTLE+3 cycles later.
    task automatic post_accept(input bit raise_at10);
        for (int i = 1; i <= SETTLE + 3; i++) begin
            step();
            if (raise_at10 && i == 10) pll_locked = 1'b1;
            if (i == SETTLE + 2) begin
                chk("done_early", done, 0);
                chk("busy_before_done", busy, 1);
            end
            if (i == SETTLE + 3) begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
                chk("error_at_done", error, 0);
            end
        end
        step();
        chk("done_one_cycle", done, 0);
    endtask

    task automatic post_timeout();
        bit seen_done = 1'b0;
        for (int i = 1; i <= SETTLE + TIMEOUT + 1; i++) begin
            step();
            if (done) seen_done = 1'b1;
            if (i == SETTLE + TIMEOUT) begin
                chk("error_before_timeout", error, 0);
                chk("busy_before_timeout", busy, 1);
            end
            if (i == SETTLE + TIMEOUT + 1) begin
                chk("error_at_timeout", error, 1);
                chk("busy_at_timeout", busy, 0);
            end
        end
        chk("no_done_on_timeout", seen_done, 0);
        repeat (3) step();
        chk("error_sticky", error, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        set_base();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_write", mgmt_write, 0);
        chk("reset_address", mgmt_address, 0);
        chk("reset_writedata", mgmt_writedata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_state", dbg_state, 0);
        rst_n = 1'b1;
        step();

        // 148.5 MHz setting, no wait states, lock rises 10 cycles into settle.
        run_writes(0, 0);
        post_accept(1'b1);
        pll_locked = 1'b0;
        repeat (4) step();

        // Five wait-state cycles on every beat, PLL already locked.
        pll_locked = 1'b1;
        repeat (3) step();
        run_writes(5, 0);
        post_accept(1'b0);

        // PLL never locks.
        pll_locked = 1'b0;
        repeat (4) step();
        run_writes(0, 0);
        post_timeout();

        // New start clears error; a second start during the K write is ignored.
        pll_locked = 1'b1;
        run_writes(0, 1);
        post_accept(1'b0);
        repeat (5) step();
        chk("no_queued_start", busy, 0);
        chk("idle_after_ignored", dbg_state, 0);

        // Reset during the C write, then a fresh sequence from the mode write.
        set_base();
        run_writes(0, 2);
        step();
        run_writes(0, 0);
        post_accept(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
